mips_inst_gen: RTL and testbench
================================

# mips_inst_gen

Instruction stimulus generator for the MIPS CPU verification environment. It drives the instruction word and `pcEn` strobe into the CPU and the checker, then waits for the checker's `OpDone` pulse. It keeps pass/fail scoreboard counts. It is the sending end of the inst/pcEn → OpDone protocol. The checker consumes instructions and this block produces them.

## Interface
Parameters:
- `NUM_INST`, 16: instructions issued per run (1..65535).
- `TIMEOUT`, 8: maximum WAIT cycles for `op_done` per instruction (≥6, since the checker answers on the 5th cycle).
- `LFSR_SEED`, 32'hACE1_2345: initial LFSR value; a seed of 0 is replaced by 32'h1.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run; sampled in IDLE or DONE.
- `op_done` in 1: `OpDone` from the checker.
- `inst` out 32: instruction word to the CPU and checker.
- `pcEn` out 1: instruction-valid strobe.
- `busy` out 1: a run is in progress.
- `done` out 1: run complete; held until the next `start`.
- `pass_cnt` out 16: instructions acknowledged within `TIMEOUT`.
- `fail_cnt` out 16: instructions that timed out.

## Operation
- States: IDLE, ISSUE, WAIT, GAP (macro-only), DONE.
- Transitions:
  - IDLE→ISSUE on `start`.
  - ISSUE→WAIT unconditionally.
  - WAIT→ISSUE/GAP/DONE when the instruction completes.
  - DONE→ISSUE on `start`. Counters, the issued count and the LFSR are reinitialised before issuing.
- Encoding uses the current LFSR value `L`. The kind is selected by `L[2:0]`:
  - 0, 1: R-type, opcode 000000. rs=`L[10:6]`, rt=`L[15:11]`, rd=`L[20:16]`, shamt=0. Funct by `L[5:3]`: ADD, SUB, AND, OR, NOR, SLT, XOR, ADD.
  - 2: ADDI (001000). imm=`L[31:16]`.
  - 3: LW (100011). imm={9'b0,`L[25:21]`,2'b00}, kept within the 7-bit data memory.
  - 4: SW (101011). Same immediate rule as LW.
  - 5: BEQ (000100). imm={12'b0,`L[19:16]`}.
  - 6: BNE (000101). Same immediate rule as BEQ.
  - 7: J (000010). target={16'b0,`L[25:16]`}.
  - For all I-types, rs and rt are taken as for R-type.
- LFSR: 32-bit Galois, taps 32'h8020_0003. It advances exactly once per completed instruction. The first instruction of a run uses the seed itself.
- Completion:
  - `op_done`=1 in WAIT: `pass_cnt`+1.
  - WAIT counter reaches `TIMEOUT` with `op_done`=0: `fail_cnt`+1.
  - `op_done` on the final WAIT cycle counts as a pass.
  - `op_done` is ignored outside WAIT.
- Counters saturate at 16'hFFFF.
- The run ends when the issued count equals `NUM_INST`.

## Timing
- Reset values (asynchronous, immediate): `inst`=32'hFFFF_FFFF (the checker's idle opcode 111111), `pcEn`=0, `busy`=0, `done`=0, `pass_cnt`=0, `fail_cnt`=0. State returns to IDLE and the LFSR reloads the seed.
- Reset during any state aborts the run; no partial count is kept.
- All outputs are registered.
- ISSUE lasts exactly 1 cycle with `pcEn`=1 and `inst` valid.
- `inst` holds its value through WAIT. It returns to 32'hFFFF_FFFF in IDLE, GAP and DONE.
- The WAIT counter runs 1..`TIMEOUT`.
- Per-instruction duration is 1+k cycles when `op_done` arrives in WAIT cycle k, and 1+`TIMEOUT` cycles on a timeout.
- `busy`=1 in ISSUE, WAIT and GAP.
- `done` rises the cycle after the last WAIT.
- `start` is ignored while `busy`=1.

## Configuration
- `MIPS_INST_GEN_GAP_EN` defined:
  - After each completion (except the last), the block enters GAP for `L[31:30]` cycles (0–3; 0 skips GAP) before the next ISSUE.
  - `pcEn`=0 during GAP.
  - The gap length is taken from `L` before the advance.
- Not defined: the GAP state is absent and WAIT goes directly to ISSUE.

## Structure
- Add the `gen_state_t` enum and the `inst_kind_t` enum (R, ADDI, LW, SW, BEQ, BNE, J) to `AluCtrlSig_pkg`.
- Reuse the package's existing opcode and funct constants.
- One sub-module, `mips_inst_gen_lfsr`, with ports clk, reset, load, advance, seed, value.

## Test plan
- `LFSR_SEED`=32'h3, `op_done` pulsed 5 cycles after `pcEn` → first `inst`=32'h8C00_0000 (LW); after `NUM_INST`=16: `pass_cnt`=16, `fail_cnt`=0, `done`=1.
- `LFSR_SEED`=0 → treated as seed 1; first `inst`=32'h0000_0020 (ADD, r0 fields).
- `op_done` tied 0, `NUM_INST`=2, `TIMEOUT`=8 → `fail_cnt`=2; `done` rises 18 cycles after the first ISSUE.
- `op_done` asserted exactly on WAIT cycle 8 with `TIMEOUT`=8 → counted as pass; a pulse during ISSUE is ignored.
- `reset` asserted mid-WAIT → same cycle: `inst`=32'hFFFF_FFFF, `pcEn`=0, `busy`=0, counts 0; a new `start` reissues the seed instruction.
- `MIPS_INST_GEN_GAP_EN` defined, `op_done` after 5 cycles → gaps of 0–3 cycles with `pcEn`=0 appear between instructions; final `pass_cnt`=`NUM_INST`.

Source files
------------

// File: rtl/AluCtrlSig_pkg.sv
// Shared ALU/opcode constants for the MIPS environment, plus the stimulus generator's
// state/kind enums and the LFSR-step and instruction-encode helpers.
package AluCtrlSig_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  // All-ones word decodes as opcode 111111, which the checker treats as idle.
  localparam logic [31:0] IDLE_INST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } gen_state_t;

  typedef enum logic [2:0] {
    KIND_R, KIND_ADDI, KIND_LW, KIND_SW, KIND_BEQ, KIND_BNE, KIND_J
  } inst_kind_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic inst_kind_t inst_kind(input logic [2:0] sel);
    case (sel)
      3'd2:    return KIND_ADDI;
      3'd3:    return KIND_LW;
      3'd4:    return KIND_SW;
      3'd5:    return KIND_BEQ;
      3'd6:    return KIND_BNE;
      3'd7:    return KIND_J;
      default: return KIND_R;
    endcase
  endfunction

  function automatic logic [5:0] r_funct(input logic [2:0] sel);
    case (sel)
      3'd1:    return FN_SUB;
      3'd2:    return FN_AND;
      3'd3:    return FN_OR;
      3'd4:    return FN_NOR;
      3'd5:    return FN_SLT;
      3'd6:    return FN_XOR;
      default: return FN_ADD;
    endcase
  endfunction

  function automatic logic [31:0] encode_inst(input logic [31:0] l);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm_mem, imm_br;
    rs = l[10:6];
    rt = l[15:11];
    rd = l[20:16];
    // Word-aligned offsets confined to the 7-bit data memory.
    imm_mem = {9'b0, l[25:21], 2'b00};
    imm_br  = {12'b0, l[19:16]};
    case (inst_kind(l[2:0]))
      KIND_ADDI: return {OP_ADDI, rs, rt, l[31:16]};
      KIND_LW:   return {OP_LW, rs, rt, imm_mem};
      KIND_SW:   return {OP_SW, rs, rt, imm_mem};
      KIND_BEQ:  return {OP_BEQ, rs, rt, imm_br};
      KIND_BNE:  return {OP_BNE, rs, rt, imm_br};
      KIND_J:    return {OP_J, 16'b0, l[25:16]};
      default:   return {OP_RTYPE, rs, rt, rd, 5'b0, r_funct(l[5:3])};
    endcase
  endfunction

endpackage

// File: rtl/mips_inst_gen_if.sv
// Instruction/strobe/acknowledge bundle between the stimulus generator and the CPU checker.
interface mips_inst_gen_if;
  logic        start;
  logic        op_done;
  logic [31:0] inst;
  logic        pcEn;
  logic        busy;
  logic        done;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;

  modport master (
    input  start, op_done,
    output inst, pcEn, busy, done, pass_cnt, fail_cnt
  );

  modport slave (
    output start, op_done,
    input  inst, pcEn, busy, done, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/mips_inst_gen_lfsr.sv
// 32-bit Galois LFSR holding the current instruction seed; load wins over advance.
module mips_inst_gen_lfsr
  import AluCtrlSig_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        value <= seed;
    else if (load)    value <= seed;
    else if (advance) value <= lfsr_step(value);
  end

endmodule

// File: rtl/mips_inst_gen.sv
// Issues NUM_INST pseudo-random MIPS instructions, one per pcEn strobe, each held until op_done or TIMEOUT.
// All outputs registered; MIPS_INST_GEN_GAP_EN inserts 0-3 idle cycles between instructions.
module mips_inst_gen
  import AluCtrlSig_pkg::*;
#(
  parameter int          NUM_INST  = 16,
  parameter int          TIMEOUT   = 8,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
  input  logic            clk,
  input  logic            reset,
  mips_inst_gen_if.master bus
);

  localparam logic [31:0]    SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam int             WCW      = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] TO_V     = WCW'(TIMEOUT);
  localparam logic [15:0]    NUM_V    = 16'(NUM_INST);

  gen_state_t     state;
  logic [WCW-1:0] wait_cnt;
  logic [15:0]    issued;
  logic [31:0]    inst_q;
  logic           pc_en_q, busy_q, done_q;
  logic [15:0]    pass_q, fail_q;
  logic [31:0]    lfsr_val, lfsr_next;
  logic           start_ok, complete;
`ifdef MIPS_INST_GEN_GAP_EN
  logic [1:0]     gap_cnt;
`endif

  assign start_ok  = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
  assign complete  = (state == ST_WAIT) && (bus.op_done || (wait_cnt == TO_V));
  assign lfsr_next = lfsr_step(lfsr_val);

  mips_inst_gen_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (start_ok),
    .advance (complete),
    .seed    (SEED_EFF),
    .value   (lfsr_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      issued   <= 16'd0;
      inst_q   <= IDLE_INST;
      pc_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 16'd0;
      fail_q   <= 16'd0;
`ifdef MIPS_INST_GEN_GAP_EN
      gap_cnt  <= 2'd0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // The LFSR reloads on this same edge, so encode straight from the seed.
          if (start_ok) begin
            state   <= ST_ISSUE;
            inst_q  <= encode_inst(SEED_EFF);
            pc_en_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 16'd0;
            fail_q  <= 16'd0;
            issued  <= 16'd1;
          end
        end
        ST_ISSUE: begin
          state    <= ST_WAIT;
          pc_en_q  <= 1'b0;
          wait_cnt <= WCW'(1);
        end
        ST_WAIT: begin
          if (complete) begin
            if (bus.op_done) pass_q <= sat_inc(pass_q);
            else             fail_q <= sat_inc(fail_q);
            if (issued == NUM_V) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              inst_q <= IDLE_INST;
            end
`ifdef MIPS_INST_GEN_GAP_EN
            else if (lfsr_val[31:30] != 2'd0) begin
              state   <= ST_GAP;
              inst_q  <= IDLE_INST;
              gap_cnt <= lfsr_val[31:30];
            end
`endif
            else begin
              state   <= ST_ISSUE;
              inst_q  <= encode_inst(lfsr_next);
              pc_en_q <= 1'b1;
              issued  <= issued + 16'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
`ifdef MIPS_INST_GEN_GAP_EN
        ST_GAP: begin
          // LFSR already advanced on entry, so it holds the next instruction's value.
          if (gap_cnt == 2'd1) begin
            state   <= ST_ISSUE;
            inst_q  <= encode_inst(lfsr_val);
            pc_en_q <= 1'b1;
            issued  <= issued + 16'd1;
          end else begin
            gap_cnt <= gap_cnt - 2'd1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.inst     = inst_q;
  assign bus.pcEn     = pc_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass_cnt = pass_q;
  assign bus.fail_cnt = fail_q;

endmodule

// File: tb/tb_mips_inst_gen.sv
// Randomized bench: a per-cycle timeline model of mips_inst_gen plus a second instance for seed-0/timeout cases.
module tb_mips_inst_gen;

  localparam int          N_A    = 16;
  localparam int          T_A    = 8;
  localparam logic [31:0] SEED_A = 32'h3;
  localparam int          TL     = 640;
`ifdef MIPS_INST_GEN_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_inst_gen_if bus_a ();
  mips_inst_gen_if bus_b ();

  mips_inst_gen #(.NUM_INST(N_A), .TIMEOUT(T_A), .LFSR_SEED(SEED_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  mips_inst_gen #(.NUM_INST(2), .TIMEOUT(8), .LFSR_SEED(32'h0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  int n_chk = 0;
  int n_ok  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_ok++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference rules written as plain arithmetic on the LFSR value.
  function automatic logic [31:0] m_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  function automatic logic [31:0] m_enc(input logic [31:0] l);
    logic [31:0] rs, rt, rd, f, base;
    rs = (l >> 6) & 32'h1F;
    rt = (l >> 11) & 32'h1F;
    rd = (l >> 16) & 32'h1F;
    base = (rs << 21) | (rt << 16);
    case (l & 32'h7)
      32'd0, 32'd1: begin
        case ((l >> 3) & 32'h7)
          32'd1:   f = 32'd34;
          32'd2:   f = 32'd36;
          32'd3:   f = 32'd37;
          32'd4:   f = 32'd39;
          32'd5:   f = 32'd42;
          32'd6:   f = 32'd38;
          default: f = 32'd32;
        endcase
        return base | (rd << 11) | f;
      end
      32'd2:   return (32'h08 << 26) | base | (l >> 16);
      32'd3:   return (32'h23 << 26) | base | (((l >> 21) & 32'h1F) << 2);
      32'd4:   return (32'h2B << 26) | base | (((l >> 21) & 32'h1F) << 2);
      32'd5:   return (32'h04 << 26) | base | ((l >> 16) & 32'hF);
      32'd6:   return (32'h05 << 26) | base | ((l >> 16) & 32'hF);
      default: return (32'h02 << 26) | ((l >> 16) & 32'h3FF);
    endcase
  endfunction

  int          k_tab [N_A];
  bit          spur_tab [N_A];
  logic [31:0] e_inst [TL];
  logic [2:0]  e_ctl [TL];   // {pcEn, busy, done}
  logic [31:0] e_cnt [TL];   // {pass_cnt, fail_cnt}
  int          t_len = 0;
  int          exp_pass, exp_fail;

  task automatic build_model();
    logic [31:0] l;
    int t, w, g, p, f;
    l = SEED_A; t = 0; p = 0; f = 0;
    for (int i = 0; i < N_A; i++) begin
      w = (k_tab[i] <= T_A) ? k_tab[i] : T_A;
      for (int c = 0; c <= w; c++) begin
        e_inst[t+c] = m_enc(l);
        e_ctl[t+c]  = {c == 0, 1'b1, 1'b0};
        e_cnt[t+c]  = {p[15:0], f[15:0]};
      end
      t += w + 1;
      if (k_tab[i] <= T_A) p++; else f++;
      g = (GAP_EN && i != N_A - 1) ? int'(l[31:30]) : 0;
      for (int c = 0; c < g; c++) begin
        e_inst[t+c] = 32'hFFFF_FFFF;
        e_ctl[t+c]  = 3'b010;
        e_cnt[t+c]  = {p[15:0], f[15:0]};
      end
      t += g;
      l = m_step(l);
    end
    for (int c = 0; c < 3; c++) begin
      e_inst[t+c] = 32'hFFFF_FFFF;
      e_ctl[t+c]  = 3'b001;
      e_cnt[t+c]  = {p[15:0], f[15:0]};
    end
    t_len = t + 3;
    exp_pass = p;
    exp_fail = f;
  endtask

  int          cyc = 0;
  int          run_base = 0;
  bit          cmp_on = 1'b0;
  logic [31:0] first_inst = 32'h0;
  int          resp_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmp_on) begin
      int r;
      r = cyc - run_base;
      if (r >= 0 && r < t_len) begin
        chk($sformatf("inst@%0d", r), bus_a.inst, e_inst[r]);
        chk($sformatf("pcEn_busy_done@%0d", r),
            {29'b0, bus_a.pcEn, bus_a.busy, bus_a.done}, {29'b0, e_ctl[r]});
        chk($sformatf("pass_fail@%0d", r), {bus_a.pass_cnt, bus_a.fail_cnt}, e_cnt[r]);
        if (r == 0) first_inst = bus_a.inst;
      end
    end
  end

  // Checker stand-in: acknowledges WAIT cycle k of each instruction (k > TIMEOUT never answers),
  // optionally with a stray pulse during ISSUE.
  initial begin
    bus_a.op_done = 1'b0;
    forever begin
      @(negedge clk);
      bus_a.op_done = 1'b0;
      if (bus_a.pcEn === 1'b1 && reset === 1'b0) begin
        int kk;
        kk = k_tab[resp_idx % N_A];
        bus_a.op_done = spur_tab[resp_idx % N_A];
        resp_idx++;
        for (int j = 1; j <= T_A; j++) begin
          @(negedge clk);
          bus_a.op_done = (j == kk);
          if (j == kk) break;
        end
      end
    end
  end

  task automatic rand_tables();
    for (int i = 0; i < N_A; i++) begin
      k_tab[i]    = int'($urandom_range(1, T_A + 3));
      spur_tab[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_run(input string nm);
    resp_idx = 0;
    build_model();
    @(negedge clk);
    bus_a.start = 1'b1;
    run_base = cyc + 1;
    cmp_on = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    while (cyc < run_base + t_len) @(negedge clk);
    cmp_on = 1'b0;
    chk({nm, "_pass_cnt"}, {16'b0, bus_a.pass_cnt}, exp_pass);
    chk({nm, "_fail_cnt"}, {16'b0, bus_a.fail_cnt}, exp_fail);
    chk({nm, "_done"}, {31'b0, bus_a.done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b_base, b_done;
    reset = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_b.op_done = 1'b0;
    for (int i = 0; i < N_A; i++) begin k_tab[i] = 5; spur_tab[i] = 1'b0; end

    // Pin the model to hand-decoded words.
    chk("model_lw_seed3", m_enc(32'h3), 32'h8C00_0000);
    chk("model_add_seed1", m_enc(32'h1), 32'h0000_0020);
    chk("model_addi", m_enc(32'h2), 32'h2000_0000);
    chk("model_step", m_step(32'h1), 32'h8020_0003);

    #2;
    chk("rst_inst_a", bus_a.inst, 32'hFFFF_FFFF);
    chk("rst_ctl_a", {29'b0, bus_a.pcEn, bus_a.busy, bus_a.done}, 32'd0);
    chk("rst_cnt_a", {bus_a.pass_cnt, bus_a.fail_cnt}, 32'd0);
    chk("rst_inst_b", bus_b.inst, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Run 1: checker answers on WAIT cycle 5 every time.
    do_run("run1");
    chk("run1_first_inst", first_inst, 32'h8C00_0000);
    chk("run1_pass16", {16'b0, bus_a.pass_cnt}, 32'd16);

    // Run 2: random latencies, boundary ack on the last WAIT cycle, a timeout, stray ISSUE pulses.
    rand_tables();
    k_tab[0] = T_A; spur_tab[0] = 1'b1;
    k_tab[1] = T_A + 1;
    do_run("run2");

    rand_tables();
    do_run("run3");

    // Reset in the middle of WAIT of the fourth instruction.
    for (int i = 0; i < N_A; i++) begin k_tab[i] = 5; spur_tab[i] = 1'b0; end
    resp_idx = 0;
    build_model();
    @(negedge clk);
    bus_a.start = 1'b1;
    run_base = cyc + 1;
    @(negedge clk);
    bus_a.start = 1'b0;
    while (cyc < run_base + 20) @(negedge clk);
    chk("pre_reset_cnt", {bus_a.pass_cnt, bus_a.fail_cnt}, e_cnt[20]);
    #1 reset = 1'b1;
    #1;
    chk("midrst_inst", bus_a.inst, 32'hFFFF_FFFF);
    chk("midrst_ctl", {29'b0, bus_a.pcEn, bus_a.busy, bus_a.done}, 32'd0);
    chk("midrst_cnt", {bus_a.pass_cnt, bus_a.fail_cnt}, 32'd0);
    repeat (15) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    rand_tables();
    first_inst = 32'h0;
    do_run("run4");
    chk("run4_first_inst", first_inst, 32'h8C00_0000);

    // Seed 0 instance with the checker silent: two timeouts.
    @(negedge clk);
    bus_b.start = 1'b1;
    b_base = cyc + 1;
    @(negedge clk);
    bus_b.start = 1'b0;
    chk("b_first_inst", bus_b.inst, 32'h0000_0020);
    chk("b_first_pcen", {31'b0, bus_b.pcEn}, 32'd1);
    b_done = -1;
    for (int i = 0; i < 40 && b_done < 0; i++) begin
      @(negedge clk);
      if (bus_b.done === 1'b1) b_done = cyc - b_base;
    end
    chk("b_done_latency", b_done, 32'd18);
    chk("b_fail_cnt", {16'b0, bus_b.fail_cnt}, 32'd2);
    chk("b_pass_cnt", {16'b0, bus_b.pass_cnt}, 32'd0);
    chk("b_end_ctl", {29'b0, bus_b.pcEn, bus_b.busy, bus_b.done}, 32'd1);
    chk("b_end_inst", bus_b.inst, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
